// File: rtl/pudiannao_pkg.sv
// Shared types and default sizes for the operand path feeding the 16-input adder tree.
package pudiannao_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LANES_DEF = 16;
  localparam int CNT_W_DEF = $clog2(LANES_DEF) + 1;

  typedef logic [WIDTH_DEF-1:0] operand_t;
  typedef operand_t lane_vec_t [LANES_DEF-1:0];
  typedef logic [CNT_W_DEF-1:0] count_t;

endpackage

// File: rtl/feeder_out_reg.sv
// Output register of the feeder: loads a packed vector, holds it while the tree stalls,
// and drops valid once drained. Data is kept after draining.
module feeder_out_reg #(
  parameter int WIDTH = 32,
  parameter int LANES = 16,
  parameter int CNT_W = $clog2(LANES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data [LANES-1:0],
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data [LANES-1:0],
  output logic [CNT_W-1:0] out_count
);

  // The feeder only asserts load when the register is empty or draining this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      for (int i = 0; i < LANES; i++) out_data[i] <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_count <= load_count;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand packer for the adder tree; LANES operands per output vector.
// Optional macro FEEDER_FLUSH_EN: in_last completes a vector early, padding with zeros.
module adder_tree_feeder
  import pudiannao_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = $clog2(LANES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [LANES-1:0],
  output logic [CNT_W-1:0] out_count
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] fill     [LANES-1:0];
  logic [WIDTH-1:0] load_vec [LANES-1:0];
  logic [CNT_W-1:0] load_count;
  logic             ends_vec;
  logic             out_busy;
  logic             xfer;
  logic             complete;

`ifdef FEEDER_FLUSH_EN
  assign ends_vec = (idx == LAST_IDX) || in_last;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign ends_vec    = (idx == LAST_IDX);
`endif

  // Only a word that would complete a vector needs the output register free.
  assign out_busy = out_valid && !out_ready;
  assign in_ready = !out_busy || !ends_vec;
  assign xfer     = in_valid && in_ready;
  assign complete = xfer && ends_vec;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    load_vec      = fill;
    load_vec[idx] = in_data;
    load_count    = CNT_W'(idx) + CNT_W'(1);
  end

  // NOTE: the fill buffer is reset because unwritten lanes must read as 0 (additive identity).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      for (int i = 0; i < LANES; i++) fill[i] <= '0;
    end else if (complete) begin
      idx <= '0;
      for (int i = 0; i < LANES; i++) fill[i] <= '0;
    end else if (xfer) begin
      fill[idx] <= in_data;
      idx       <= idx + IDX_W'(1);
    end
  end

  feeder_out_reg #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .load_data (load_vec),
    .load_count(load_count),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count)
  );

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Self-checking bench for adder_tree_feeder: directed scenarios plus a randomized stream,
// all checked against a queue-based model of operand grouping.
module tb_adder_tree_feeder;
  import pudiannao_pkg::*;

  localparam int LANES = LANES_DEF;

  logic      clk = 1'b0;
  logic      rst;
  logic      in_valid;
  logic      in_ready;
  operand_t  in_data;
  logic      in_last;
  logic      out_valid;
  logic      out_ready;
  lane_vec_t out_data;
  count_t    out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_tree_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted words are grouped into vectors by count (or by in_last when
  // flushing is built in); each finished vector is queued until the tree side accepts it.
  typedef struct {
    lane_vec_t   lanes;
    int unsigned cnt;
    longint      sum;
  } vec_t;

  vec_t     exp_q[$];
  operand_t grp[$];
  logic     lat_pending  = 1'b0;
  logic     hold_pending = 1'b0;
  lane_vec_t   held_data;
  logic [63:0] held_cnt;
  bit       flush_en;
  bit       rand_ready = 1'b0;

  initial begin
`ifdef FEEDER_FLUSH_EN
    flush_en = 1'b1;
`else
    flush_en = 1'b0;
`endif
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      grp.delete();
      lat_pending  = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (lat_pending) begin
        check("lat_valid", out_valid, 1);
        if (exp_q.size() > 0) check("lat_count", out_count, exp_q[$].cnt);
      end else if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_count", out_count, held_cnt);
        for (int i = 0; i < LANES; i++) check($sformatf("hold_lane%0d", i), out_data[i], held_data[i]);
      end
      if (out_valid) check("no_spurious", exp_q.size() > 0, 1);
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      held_cnt     = out_count;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        vec_t   v;
        longint s;
        v = exp_q.pop_front();
        s = 0;
        for (int i = 0; i < LANES; i++) begin
          check($sformatf("lane%0d", i), out_data[i], v.lanes[i]);
          s += longint'(out_data[i]);
        end
        check("count", out_count, v.cnt);
        check("tree_sum", s, v.sum);
      end
      lat_pending = 1'b0;
      if (in_valid && in_ready) begin
        grp.push_back(in_data);
        if (grp.size() == LANES || (flush_en && in_last)) begin
          vec_t v;
          v.cnt = grp.size();
          v.sum = 0;
          for (int i = 0; i < LANES; i++) begin
            v.lanes[i] = (i < grp.size()) ? grp[i] : '0;
            v.sum += longint'(v.lanes[i]);
          end
          exp_q.push_back(v);
          grp.delete();
          lat_pending = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input operand_t d, input logic last, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits >= 500) begin
        check("send_timeout", waits, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() > 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_count"}, out_count, 0);
    for (int i = 0; i < LANES; i++) check($sformatf("%s_lane%0d", tag, i), out_data[i], 0);
  endtask

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    check("reset_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous stream, tree always ready: no stall on any word.
    for (int k = 1; k <= 32; k++) begin
      send(operand_t'(k), 1'b0, w);
      check("stream_no_stall", w, 0);
    end
    drain("stream_drain");

    // Tree stalls after the first vector: only the completing word waits.
    out_ready = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      send(operand_t'(k), 1'b0, w);
      check("stall_early_accept", w, 0);
    end
    in_valid = 1'b1; in_data = 32; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("stall_drain");

    // Short group ended by in_last (early flush only when the feature is built in).
    send(5, 1'b0, w);
    send(6, 1'b0, w);
    send(7, 1'b1, w);
    repeat (3) @(posedge clk);
    #1;
`ifdef FEEDER_FLUSH_EN
    check("flush_done", exp_q.size(), 0);
`else
    check("no_flush_valid", out_valid, 0);
`endif
    for (int k = 1; k <= 13; k++) send(operand_t'(k), 1'b0, w);
    drain("flush_drain");

    // Reset mid-vector discards the partial fill.
    for (int k = 0; k < 9; k++) send(operand_t'(100 + k), 1'b0, w);
    rst = 1'b1;
    #2;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) send(32'hA5, 1'b0, w);
    drain("a5_drain");

    // Randomized traffic on both sides.
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      while ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
      send(operand_t'($urandom), 1'($urandom_range(0, 7) == 0), w);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    drain("random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
